// File: rtl/vga_scan_out.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_out
// Purpose  : Scan-out stage of the display plane. Pops 24-bit pixels from a
//            first-word-fall-through pixel FIFO and drives VGA timing (hsync,
//            vsync, blank) plus RGB. Owns the pixel-rate divider and the
//            horizontal/vertical counters. The screen stays blank until the
//            FIFO first reports full; any pop attempt on an empty FIFO during
//            active video sets a sticky underflow flag.
// Ports    : clk_i          system clock, rising edge
//            rst_ni         asynchronous reset, active low
//            fifo_empty_i   pixel FIFO empty
//            fifo_full_i    pixel FIFO full
//            fifo_dout_i    FIFO head word {R,G,B}, valid when !fifo_empty_i
//            fifo_rd_o      pop strobe, one clk wide (combinational)
//            hsync_o        horizontal sync, active low (registered)
//            vsync_o        vertical sync, active low (registered)
//            blank_o        high outside active video (registered)
//            vga_rgb_o      pixel to DAC, zero while blanked (registered)
//            frame_start_o  one-clk pulse at the first pixel of each frame
//            underflow_o    sticky underflow flag, cleared only by reset
// Revision : 1.0 - initial release
// ============================================================================
module vga_scan_out #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fifo_empty_i,
  input  logic        fifo_full_i,
  input  logic [23:0] fifo_dout_i,
  output logic        fifo_rd_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        blank_o,
  output logic [23:0] vga_rgb_o,
  output logic        frame_start_o,
  output logic        underflow_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  // A divide-by-one still needs a one-bit counter that simply stays at zero.
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [HW-1:0]    H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]    V_LAST   = VW'(V_TOTAL - 1);

  // Window bounds kept 32 bits wide: the sync end can equal TOTAL when the
  // back porch is zero, which would not fit in the counter width.
  localparam logic [31:0] H_ACT_END = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT_END = 32'(V_ACTIVE);
  localparam logic [31:0] HS_START  = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END    = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_START  = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END    = 32'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [0:0] {
    WAIT_FILL = 1'b0,
    RUN       = 1'b1
  } state_e;

  state_e           state_q;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [HW-1:0]    h_cnt_q, h_cnt_d;
  logic [VW-1:0]    v_cnt_q, v_cnt_d;

  logic             hsync_q, vsync_q, blank_q, frame_start_q, underflow_q;
  logic [23:0]      vga_rgb_q;

  logic             pix_tick;
  logic             active;
  logic             hs_win;
  logic             vs_win;
  logic [31:0]      h_ext;
  logic [31:0]      v_ext;

  assign h_ext    = 32'(h_cnt_q);
  assign v_ext    = 32'(v_cnt_q);

  assign pix_tick = (state_q == RUN) && (div_cnt_q == '0);
  assign active   = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
  assign hs_win   = (h_ext >= HS_START) && (h_ext < HS_END);
  assign vs_win   = (v_ext >= VS_START) && (v_ext < VS_END);

  // The pop lands on the same edge that captures the head word into vga_rgb.
  assign fifo_rd_o = pix_tick && active && !fifo_empty_i;

  // Divider and raster counters; all frozen at zero while waiting for fill.
  always_comb begin
    div_cnt_d = div_cnt_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    if (state_q == RUN) begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    end
    if (pix_tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= WAIT_FILL;
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_q       <= 1'b1;
      vga_rgb_q     <= '0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= 1'b0;

      case (state_q)
        WAIT_FILL: if (fifo_full_i) state_q <= RUN;
        RUN:       state_q <= RUN;
        default:   state_q <= WAIT_FILL;
      endcase

      if (pix_tick) begin
        hsync_q       <= !hs_win;
        vsync_q       <= !vs_win;
        frame_start_q <= (h_cnt_q == '0) && (v_cnt_q == '0);
        if (active) begin
          blank_q <= 1'b0;
          if (!fifo_empty_i) begin
            vga_rgb_q <= fifo_dout_i;
          end else begin
            // Starved pixel shows black; counters keep running so the
            // raster never needs resynchronising.
            vga_rgb_q   <= '0;
            underflow_q <= 1'b1;
          end
        end else begin
          blank_q   <= 1'b1;
          vga_rgb_q <= '0;
        end
      end
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign blank_o       = blank_q;
  assign vga_rgb_o     = vga_rgb_q;
  assign frame_start_o = frame_start_q;
  assign underflow_o   = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scan_out
// Purpose  : Directed self-checking bench for vga_scan_out using a reduced
//            raster (16 x 8 total, 8 x 4 active, CLK_DIV=2) so a whole frame
//            is 256 clks. A small FIFO model supplies 1, 2, 3, ...
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_scan_out;

  logic        clk;
  logic        rst_n;
  logic        fifo_empty;
  logic        fifo_full;
  logic [23:0] fifo_dout;
  logic        fifo_rd;
  logic        hsync;
  logic        vsync;
  logic        blank;
  logic [23:0] vga_rgb;
  logic        frame_start;
  logic        underflow;

  // FIFO model: head value advances on every accepted pop.
  logic [23:0] head = 24'd1;
  assign fifo_dout = head;
  always @(posedge clk) if (fifo_rd) head <= head + 24'd1;

  vga_scan_out #(
    .CLK_DIV (2),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .fifo_empty_i (fifo_empty),
    .fifo_full_i  (fifo_full),
    .fifo_dout_i  (fifo_dout),
    .fifo_rd_o    (fifo_rd),
    .hsync_o      (hsync),
    .vsync_o      (vsync),
    .blank_o      (blank),
    .vga_rgb_o    (vga_rgb),
    .frame_start_o(frame_start),
    .underflow_o  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int t     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  // Outputs are sampled on the falling edge, half a cycle from the active edge.
  task automatic step();
    @(negedge clk);
    t++;
  endtask

  task automatic run_to(input int n);
    while (t < n) step();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rd"},    32'(fifo_rd), 32'd0);
    check({tag, "_blank"}, 32'(blank),   32'd1);
    check({tag, "_hs"},    32'(hsync),   32'd1);
    check({tag, "_vs"},    32'(vsync),   32'd1);
    check({tag, "_rgb"},   32'(vga_rgb), 32'd0);
  endtask

  initial begin
    int n_act, n_hs, n_vs, n_rd, n_fs, first_hs, first_vs;
    logic [23:0] exp_px;
    logic prev_rd;

    rst_n      = 1'b0;
    fifo_full  = 1'b0;
    fifo_empty = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_idle("reset");
    check("reset_fs", 32'(frame_start), 32'd0);
    check("reset_uf", 32'(underflow),   32'd0);

    // Hold in WAIT_FILL for 10000 ns with data present but FIFO not full
    rst_n = 1'b1;
    repeat (1000) begin
      step();
      check_idle("hold");
    end

    // Fill reported: next edge enters RUN, following clk is pixel-0 tick
    fifo_full = 1'b1;
    step();
    check("first_rd", 32'(fifo_rd),     32'd1);
    check("first_fs", 32'(frame_start), 32'd0);
    fifo_full = 1'b0;
    step();
    check("fs_pulse",  32'(frame_start), 32'd1);
    check("px0_rgb",   32'(vga_rgb),     32'd1);
    check("px0_blank", 32'(blank),       32'd0);
    check("px0_rd",    32'(fifo_rd),     32'd0);

    // One full frame window (256 clks) starting at the frame_start sample
    t = 0;
    n_act = 0; n_hs = 0; n_vs = 0; n_rd = 0; n_fs = 0;
    first_hs = -1; first_vs = -1;
    exp_px = 24'd1;
    prev_rd = 1'b1;
    repeat (256) begin
      if (prev_rd) begin
        check("pixel_seq", 32'(vga_rgb), 32'(exp_px));
        check("pixel_blank", 32'(blank), 32'd0);
        exp_px = exp_px + 24'd1;
      end
      if (blank) check("blank_rgb0", 32'(vga_rgb), 32'd0);
      if (!blank) n_act++;
      if (!hsync) begin
        n_hs++;
        if (first_hs < 0) first_hs = t;
      end
      if (!vsync) begin
        n_vs++;
        if (first_vs < 0) first_vs = t;
      end
      if (fifo_rd) n_rd++;
      if (frame_start) n_fs++;
      prev_rd = fifo_rd;
      step();
    end
    check("active_clks",   32'(n_act),    32'd64);
    check("hsync_low",     32'(n_hs),     32'd48);
    check("vsync_low",     32'(n_vs),     32'd64);
    check("pops_frame",    32'(n_rd),     32'd32);
    check("fs_per_frame",  32'(n_fs),     32'd1);
    check("hsync_fall",    32'(first_hs), 32'd20);
    check("vsync_fall",    32'(first_vs), 32'd160);
    check("fs_period",     32'(frame_start), 32'd1);
    check("f2_px0_rgb",    32'(vga_rgb),  32'd33);

    // Underflow: FIFO empty for pixels 3..5 of the first line of frame 2
    run_to(260);
    check("pre_uf", 32'(underflow), 32'd0);
    fifo_empty = 1'b1;
    run_to(261); check("uf_rd_a", 32'(fifo_rd), 32'd0);
    run_to(262); check("uf_rgb_a", 32'(vga_rgb), 32'd0);
                 check("uf_blank_a", 32'(blank), 32'd0);
                 check("uf_flag", 32'(underflow), 32'd1);
    run_to(263); check("uf_rd_b", 32'(fifo_rd), 32'd0);
    run_to(264); check("uf_rgb_b", 32'(vga_rgb), 32'd0);
                 check("uf_blank_b", 32'(blank), 32'd0);
    run_to(265); check("uf_rd_c", 32'(fifo_rd), 32'd0);
    run_to(266); check("uf_rgb_c", 32'(vga_rgb), 32'd0);
                 check("uf_blank_c", 32'(blank), 32'd0);
    fifo_empty = 1'b0;
    run_to(267); check("resume_rd", 32'(fifo_rd), 32'd1);
    run_to(268); check("resume_rgb", 32'(vga_rgb), 32'd36);
    run_to(275); check("uf_hs_before", 32'(hsync), 32'd1);
    run_to(276); check("uf_hs_fall", 32'(hsync), 32'd0);
    run_to(300); check("uf_sticky", 32'(underflow), 32'd1);
                 check("mid_line_active", 32'(blank), 32'd0);

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    check("async_fs", 32'(frame_start), 32'd0);
    check("async_uf", 32'(underflow),   32'd0);
    step();
    rst_n = 1'b1;
    repeat (10) begin
      step();
      check_idle("refill");
      check("refill_uf", 32'(underflow), 32'd0);
    end
    fifo_full = 1'b1;
    step();
    check("re_rd", 32'(fifo_rd), 32'd1);
    exp_px = fifo_dout;
    fifo_full = 1'b0;
    step();
    check("re_fs",    32'(frame_start), 32'd1);
    check("re_rgb",   32'(vga_rgb),     32'(exp_px));
    check("re_blank", 32'(blank),       32'd0);
    check("re_hs",    32'(hsync),       32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_scan_out.md
# vga_scan_out

Downstream stage of the display plane: pops 24-bit pixels from the pixel FIFO the display plane fills, and drives the VGA connector timing (hsync, vsync, blank) and RGB. It owns the horizontal/vertical counters and the pixel-rate enable. It holds the screen blank until the FIFO has first reported full. It flags any FIFO underflow seen during active video.

## Interface
- CLK_DIV, 2: system clocks per pixel; ≥1.
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal pixels. H_TOTAL = sum = 800.
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical lines. V_TOTAL = sum = 525.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  pixel FIFO empty.
- fifo_full  in  1  pixel FIFO full.
- fifo_dout  in  24  FIFO head word, first-word-fall-through; valid whenever !fifo_empty. Packed {R[23:16],G[15:8],B[7:0]}.
- fifo_rd  out  1  pop strobe, one clk wide.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- blank  out  1  high outside active video.
- vga_rgb  out  24  pixel to DAC; 0 whenever blank.
- frame_start  out  1  one-clk pulse at the start of each frame.
- underflow  out  1  sticky; set on a pop attempt while empty.

## Operation
- States: WAIT_FILL and RUN.
- WAIT_FILL (entered on reset):
  - div_cnt, h_cnt and v_cnt held at 0.
  - Outputs: hsync=1, vsync=1, blank=1, vga_rgb=0, fifo_rd=0.
  - Transition to RUN on the first clk edge where fifo_full=1.
- RUN is never left except by reset.
- div_cnt: counts 0..CLK_DIV-1 and wraps. pix_tick = (state==RUN && div_cnt==0).
- Counters on pix_tick:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0.
  - v_cnt increments when h_cnt wraps; at V_TOTAL-1 it wraps to 0.
- Decode from the current h_cnt/v_cnt:
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hsync low for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync low for V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC.
- On pix_tick with active:
  - if !fifo_empty: fifo_rd=1 for that clk; vga_rgb<=fifo_dout; blank<=0.
  - if fifo_empty: fifo_rd=0; vga_rgb<=0; blank<=0; underflow<=1. Counters still advance, so no resync.
- On pix_tick with !active: vga_rgb<=0, blank<=1, fifo_rd=0.
- frame_start: one-clk pulse on the pix_tick where h_cnt==0 && v_cnt==0. This includes the first tick after entering RUN.
- The FIFO is never popped outside active video. Exactly H_ACTIVE×V_ACTIVE pops per underflow-free frame.
- Counter widths: 10 bits each at the defaults; in general, clog2 of the respective TOTAL.

## Timing
- Reset (rst=0, asynchronous): state=WAIT_FILL, all counters 0. Outputs: hsync=1, vsync=1, blank=1, vga_rgb=0, fifo_rd=0, frame_start=0, underflow=0.
- Reset asserted mid-frame takes effect immediately, without waiting for clk. After release the block waits for fifo_full again.
- fifo_rd is combinational from state/counters/fifo_empty and asserted in the pix_tick clk. The FIFO pops on that same edge.
- hsync, vsync, blank, vga_rgb and frame_start are registered on the pix_tick edge. They update once per pixel and are stable for CLK_DIV clks.
- Latency: counter state to pins is 1 clk; FIFO head to vga_rgb is 1 clk.
- fifo_full and fifo_empty asserted together is not legal from the FIFO. If it occurs, the full→RUN rule applies and empty governs pops.
- underflow clears only on reset.

## Test plan
- Reset/hold: release rst with fifo_full=0 for 10000 ns.
  - Expect fifo_rd never asserted, blank=1, hsync=vsync=1, vga_rgb=0.
  - Assert fifo_full=1: expect frame_start within 1 clk of the first pix_tick, then the first pop.
- Line timing at defaults, CLK_DIV=2:
  - hsync period 1600 clks, low for 192 clks.
  - hsync falls 1312 clks after the pixel-0 tick.
  - 1280 clks with blank=0 per active line.
- Frame timing:
  - vsync period 840000 clks, low for 2 lines (3200 clks).
  - frame_start period 840000 clks.
  - 307200 fifo_rd pulses per frame.
- Data path: FIFO model holding an incrementing pattern 0x000001, 0x000002, ….
  - vga_rgb shows the same sequence with no gaps or repeats.
  - vga_rgb=0 whenever blank=1.
- Underflow: force fifo_empty=1 for 3 active pixels mid-line.
  - Expect vga_rgb=0 and blank=0 for those pixels, no fifo_rd, underflow=1.
  - hsync timing unchanged; underflow stays 1 until rst.
- Async reset mid-line: pulse rst low between clk edges.
  - Expect outputs at reset values before the next clk edge.
  - Re-run the WAIT_FILL behaviour.
